// File: rtl/smash_pkg.sv
// Shared attack-word layout, per-attack damage table and resolver state encoding
// for the victim-side hit resolution path.
package smash_pkg;

  localparam int unsigned HIT_BIT       = 0;
  localparam int unsigned TYPE_LSB      = 1;
  localparam int unsigned TYPE_MSB      = 10;
  localparam int unsigned ATTACKING_BIT = 11;

  localparam logic [9:0] DMG_SMASH   = 10'd15;
  localparam logic [9:0] DMG_JAB     = 10'd3;
  localparam logic [9:0] DMG_SPEC_UD = 10'd8;
  localparam logic [9:0] DMG_SPEC_LR = 10'd10;
  localparam logic [9:0] DMG_SPEC_N  = 10'd5;

  // Indexed by type bit position (0 = smashU ... 9 = specN).
  localparam logic [9:0] DAMAGE_AMOUNT [10] = '{
    DMG_SMASH, DMG_SMASH, DMG_SMASH, DMG_SMASH, DMG_JAB,
    DMG_SPEC_UD, DMG_SPEC_UD, DMG_SPEC_LR, DMG_SPEC_LR, DMG_SPEC_N
  };

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    APPLY,
    STUN
  } state_t;

  function automatic logic [9:0] damageAmount(input logic [9:0] typeBits);
    logic       found;
    logic [9:0] amount;
    found  = 1'b0;
    amount = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (typeBits[i] && !found) begin
        amount = DAMAGE_AMOUNT[i];
        found  = 1'b1;
      end
    end
    return amount;
  endfunction

endpackage

// File: rtl/kb_scale.sv
// Combinational knockback scaler: s = sat16(k + ((k * d) >>> 6)),
// with k a signed 16-bit component and d the unsigned victim damage.
module kb_scale (
  input  logic signed [15:0] k,
  input  logic        [9:0]  d,
  output logic signed [15:0] s
);

  logic signed [25:0] kExt;
  logic signed [25:0] dExt;
  logic signed [25:0] prod;
  logic signed [26:0] sum;

  assign kExt = 26'(k);
  assign dExt = {16'b0, d};
  assign prod = kExt * dExt;
  assign sum  = 27'(k) + 27'(prod >>> 6);

  always_comb begin
    s = sum[15:0];
    if (sum > 27'sd32767) begin
      s = 16'sh7FFF;
    end else if (sum < -27'sd32768) begin
      s = 16'sh8000;
    end
  end

endmodule

// File: rtl/hit_resolver.sv
// Victim-side hit resolver: accumulates damage, emits a damage-scaled knockback
// impulse and tracks the hitstun window in frame ticks.
module hit_resolver
  import smash_pkg::*;
#(
  parameter int unsigned HITSTUN_BASE = 12,
  parameter int unsigned DAMAGE_MAX   = 999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] attack,
  input  logic [31:0] knockback,
  input  logic        tick,
  input  logic        clear_damage,
  output logic [15:0] damage,
  output logic [31:0] kb_vel,
  output logic        kb_valid,
  output logic        hitstun,
  output logic [7:0]  hit_count
);

  state_t      state;
  state_t      nextState;
  logic        armed;
  logic        fromStun;
  logic [9:0]  dmg;
  logic [7:0]  stunCnt;
  logic        hitEligible;
  logic        accept;
  logic [10:0] dmgSum;
  logic [9:0]  dmgNext;
  logic [7:0]  stunLoad;
  logic [15:0] scaledX;
  logic [15:0] scaledY;
  logic        unusedAttackBits;

  assign unusedAttackBits = ^attack[31:12];

  // Eligibility ignores clear_damage so a discarded hit still consumes armed.
  assign hitEligible = attack[HIT_BIT] && armed && (state == IDLE || state == STUN);
  assign accept      = hitEligible && !clear_damage;

  assign dmgSum   = {1'b0, dmg} + {1'b0, damageAmount(attack[TYPE_MSB:TYPE_LSB])};
  assign dmgNext  = (dmgSum > 11'(DAMAGE_MAX)) ? 10'(DAMAGE_MAX) : dmgSum[9:0];
  assign stunLoad = 8'(HITSTUN_BASE) + 8'(dmg >> 3);
  assign damage   = {6'b0, dmg};

  kb_scale uScaleX (
    .k (knockback[31:16]),
    .d (dmg),
    .s (scaledX)
  );

  kb_scale uScaleY (
    .k (knockback[15:0]),
    .d (dmg),
    .s (scaledY)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    kb_valid  = 1'b0;
    hitstun   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) nextState = CAPTURE;
      end
      CAPTURE: begin
        nextState = APPLY;
        hitstun   = fromStun;
      end
      APPLY: begin
        nextState = STUN;
        kb_valid  = 1'b1;
        hitstun   = 1'b1;
      end
      STUN: begin
        hitstun = 1'b1;
        if (accept) begin
          nextState = CAPTURE;
        end else if (tick && stunCnt <= 8'd1) begin
          nextState = IDLE;
        end
      end
    endcase
    if (clear_damage) nextState = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed     <= 1'b1;
      fromStun  <= 1'b0;
      dmg       <= '0;
      stunCnt   <= '0;
      kb_vel    <= '0;
      hit_count <= '0;
    end else begin
      if (!attack[ATTACKING_BIT]) begin
        armed <= 1'b1;
      end else if (hitEligible) begin
        armed <= 1'b0;
      end

      if (clear_damage) begin
        dmg      <= '0;
        fromStun <= 1'b0;
        stunCnt  <= '0;
      end else begin
        if (accept) begin
          dmg       <= dmgNext;
          hit_count <= hit_count + 8'd1;
          fromStun  <= (state == STUN);
        end
        if (state == CAPTURE) begin
          kb_vel <= {scaledX, scaledY};
        end
        if (state == APPLY) begin
          stunCnt <= stunLoad;
        end else if (state == STUN && tick && !accept) begin
          stunCnt <= stunCnt - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hit_resolver.sv
// Self-checking bench for hit_resolver: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural reference model.
module tb_hit_resolver;

  logic        clock;
  logic        reset;
  logic [31:0] attack;
  logic [31:0] knockback;
  logic        tick;
  logic        clear_damage;
  logic [15:0] damage;
  logic [31:0] kb_vel;
  logic        kb_valid;
  logic        hitstun;
  logic [7:0]  hit_count;

  int checks;
  int failures;

  // Reference model: time since the accepted hit plus remaining stun ticks.
  int          mDamage;
  int          mCount;
  logic [31:0] mKb;
  int          mSince;     // 0 none, 1 one edge after hit, 2 two edges, 3 stun phase
  int          mStunLeft;
  bit          mFromStun;
  bit          mArmed;

  hit_resolver #(.HITSTUN_BASE(12), .DAMAGE_MAX(999)) dut (
    .clock        (clock),
    .reset        (reset),
    .attack       (attack),
    .knockback    (knockback),
    .tick         (tick),
    .clear_damage (clear_damage),
    .damage       (damage),
    .kb_vel       (kb_vel),
    .kb_valid     (kb_valid),
    .hitstun      (hitstun),
    .hit_count    (hit_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int amountOf(input logic [31:0] att);
    int table_[10] = '{15, 15, 15, 15, 3, 8, 8, 10, 10, 5};
    for (int i = 0; i < 10; i++) begin
      if (att[1 + i]) return table_[i];
    end
    return 0;
  endfunction

  function automatic logic [15:0] scaleRef(input logic [15:0] kraw, input int d);
    longint k, p, q, s;
    logic [63:0] sv;
    k = longint'($signed(kraw));
    p = k * longint'(d);
    q = p / 64;
    if (p < 0 && (p % 64) != 0) q = q - 1;
    s = k + q;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    sv = s;
    return sv[15:0];
  endfunction

  task automatic modelReset();
    mDamage = 0; mCount = 0; mKb = '0; mSince = 0;
    mStunLeft = 0; mFromStun = 0; mArmed = 1;
  endtask

  task automatic modelEdge(input logic [31:0] att, input logic [31:0] kbw, input logic tk, input logic clr);
    bit busy, inStun, hitOk, nArmed;
    busy   = (mSince == 1 || mSince == 2);
    inStun = (mSince == 3 && mStunLeft > 0);
    hitOk  = att[0] && mArmed && !busy;
    if (!att[11]) nArmed = 1;
    else if (hitOk) nArmed = 0;
    else nArmed = mArmed;
    if (clr) begin
      mDamage = 0; mSince = 0; mStunLeft = 0; mFromStun = 0;
    end else if (hitOk) begin
      mDamage = mDamage + amountOf(att);
      if (mDamage > 999) mDamage = 999;
      mCount = (mCount + 1) % 256;
      mFromStun = inStun;
      mSince = 1;
      mStunLeft = 0;
    end else if (mSince == 1) begin
      mKb = {scaleRef(kbw[31:16], mDamage), scaleRef(kbw[15:0], mDamage)};
      mSince = 2;
    end else if (mSince == 2) begin
      mStunLeft = 12 + mDamage / 8;
      mSince = 3;
    end else if (inStun && tk) begin
      mStunLeft = mStunLeft - 1;
    end
    mArmed = nArmed;
  endtask

  task automatic checkAll();
    bit expValid, expStun;
    expValid = (mSince == 2);
    expStun  = (mSince == 2) || (mSince == 3 && mStunLeft > 0) || (mSince == 1 && mFromStun);
    chk("damage", {16'b0, damage}, mDamage);
    chk("hit_count", {24'b0, hit_count}, mCount);
    chk("kb_vel", kb_vel, mKb);
    chk("kb_valid", {31'b0, kb_valid}, {31'b0, expValid});
    chk("hitstun", {31'b0, hitstun}, {31'b0, expStun});
  endtask

  task automatic step(input logic [31:0] att, input logic [31:0] kbw, input logic tk, input logic clr);
    attack = att; knockback = kbw; tick = tk; clear_damage = clr;
    modelEdge(att, kbw, tk, clr);
    @(posedge clock);
    @(negedge clock);
    checkAll();
  endtask

  task automatic doHit(input int typeBit, input logic [31:0] kbw);
    step(32'h801 | (32'd1 << typeBit), '0, 1'b0, 1'b0);
    step('0, kbw, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    int c;
    logic [31:0] a;
    logic [9:0]  typ;
    checks = 0; failures = 0;
    reset = 1'b0; attack = '0; knockback = '0; tick = 1'b0; clear_damage = 1'b0;
    modelReset();
    repeat (2) @(negedge clock);
    chk("rst_damage", {16'b0, damage}, 32'd0);
    chk("rst_kb_vel", kb_vel, 32'd0);
    chk("rst_hitstun", {31'b0, hitstun}, 32'd0);
    reset = 1'b1;

    // Reset dropped mid-stun.
    doHit(1, 32'h00030004);
    step('0, '0, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_damage", {16'b0, damage}, 32'd0);
    chk("midrst_kb_vel", kb_vel, 32'd0);
    chk("midrst_kb_valid", {31'b0, kb_valid}, 32'd0);
    chk("midrst_hitstun", {31'b0, hitstun}, 32'd0);
    chk("midrst_hit_count", {24'b0, hit_count}, 32'd0);
    modelReset();
    attack = '0; knockback = '0; tick = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step('0, '0, 1'b0, 1'b0);

    // First hit: smashR, knockback a cycle later, 13-tick hitstun.
    step(32'h811, '0, 1'b0, 1'b0);
    chk("smashR_damage", {16'b0, damage}, 32'd15);
    chk("smashR_count", {24'b0, hit_count}, 32'd1);
    chk("smashR_valid_early", {31'b0, kb_valid}, 32'd0);
    step('0, 32'h00080001, 1'b0, 1'b0);
    chk("smashR_kb_vel", kb_vel, 32'h00090001);
    chk("smashR_kb_valid", {31'b0, kb_valid}, 32'd1);
    chk("smashR_hitstun", {31'b0, hitstun}, 32'd1);
    step('0, '0, 1'b0, 1'b0);
    n = 0;
    while (hitstun && n < 200) begin
      step('0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("smashR_stun_ticks", n, 32'd13);

    // Held hit while attacking yields one hit; re-arm then second hit.
    c = mCount;
    repeat (5) step(32'h811, '0, 1'b0, 1'b0);
    repeat (3) step(32'h800, '0, 1'b0, 1'b0);
    chk("held_one_hit", {24'b0, hit_count}, 32'(c + 1));
    step('0, '0, 1'b0, 1'b0);
    step(32'h811, '0, 1'b0, 1'b0);
    chk("rearm_second_hit", {24'b0, hit_count}, 32'(c + 2));
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    // Damage 61 then jab with negative knockback.
    step('0, '0, 1'b0, 1'b1);
    doHit(1, '0); doHit(2, '0); doHit(3, '0); doHit(6, '0); doHit(7, '0);
    chk("pre_jab_damage", {16'b0, damage}, 32'd61);
    step(32'h821, '0, 1'b0, 1'b0);
    chk("jab_damage", {16'b0, damage}, 32'd64);
    step('0, 32'hFFFC0001, 1'b0, 1'b0);
    chk("jab_kb_vel", kb_vel, 32'hFFF80002);
    step('0, '0, 1'b0, 1'b0);

    // Damage saturation and knockback saturation.
    step('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 66; i++) doHit(1 + (i % 4), 32'h00010001);
    doHit(10, '0);
    chk("pre_sat_damage", {16'b0, damage}, 32'd995);
    step(32'h805, '0, 1'b0, 1'b0);
    chk("sat_damage", {16'b0, damage}, 32'd999);
    step('0, 32'h7FFF0000, 1'b0, 1'b0);
    chk("sat_kb_vel", kb_vel, 32'h7FFF0000);
    step('0, '0, 1'b0, 1'b0);

    // Clear coincident with a hit.
    repeat (20) step('0, '0, 1'b1, 1'b0);
    c = mCount;
    step(32'h803, '0, 1'b0, 1'b1);
    chk("clr_damage", {16'b0, damage}, 32'd0);
    chk("clr_count", {24'b0, hit_count}, 32'(c));
    for (int i = 0; i < 3; i++) begin
      step('0, 32'h00100010, 1'b0, 1'b0);
      chk("clr_no_pulse", {31'b0, kb_valid}, 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      a = $urandom();
      a[0] = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: typ = '0;
        1: typ = 10'($urandom());
        default: typ = 10'd1 << $urandom_range(0, 9);
      endcase
      a[10:1] = typ;
      a[11] = a[0] ? 1'b1 : ($urandom_range(0, 2) != 0);
      step(a, $urandom(), ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
